// File: rtl/elbeth_branch_predictor_pkg.sv
// Shared control-transfer opcodes and BTB reset constants for the ID-stage
// branch resolver and the IF-stage branch target buffer.
package elbeth_branch_predictor_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_JAL  = 3'd2,
    OP_JALR = 3'd3,
    OP_BLT  = 3'd4,
    OP_BGE  = 3'd5,
    OP_BLTU = 3'd6,
    OP_BGEU = 3'd7
  } op_e;

  localparam logic BTB_VALID_RST = 1'b0;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int btb_cnt_rst(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  // Weakly taken: MSB set, all lower bits clear.
  function automatic int btb_cnt_weak_taken(input int bits);
    return 1 << (bits - 1);
  endfunction

endpackage

// File: rtl/elbeth_branch_predictor_sat_counter.sv
// Saturating up/down direction counter; force_max dominates inc/dec.
module elbeth_sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                inc,
  input  logic                dec,
  input  logic                force_max,
  output logic [CNT_BITS-1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (force_max)
      nxt = '1;
    else if (inc && (cnt != '1))
      nxt = cnt + 1'b1;
    else if (dec && (cnt != '0))
      nxt = cnt - 1'b1;
  end

endmodule

// File: rtl/elbeth_branch_predictor.sv
// ID-stage branch resolution with a direct-mapped BTB and per-entry
// saturating direction counters, looked up combinationally by IF.
module elbeth_branch_predictor
  import elbeth_branch_predictor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_offset,
  input  logic [2:0]      id_operation,
  input  logic [XLEN-1:0] id_data_rs1,
  input  logic [XLEN-1:0] id_data_rs2,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  output logic [XLEN-1:0] pc_branch,
  output logic            branch_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(btb_cnt_rst(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(btb_cnt_weak_taken(CNT_BITS));

  logic [BTB_ENTRIES-1:0]                valid_q;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]     tag_q;
  logic [BTB_ENTRIES-1:0][XLEN-1:0]      target_q;
  logic [BTB_ENTRIES-1:0][CNT_BITS-1:0]  cnt_q;

  // IF lookup
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx         = if_pc[IDX+1:2];
  assign if_tag         = if_pc[XLEN-1:IDX+2];
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = if_hit && cnt_q[if_idx][CNT_BITS-1];
  assign if_pred_target = if_hit ? target_q[if_idx] : '0;

  // ID resolution
  logic [XLEN-1:0] rel_target, jalr_sum;
  logic            eq, lt_s, lt_u, op_defined, is_jump;

  assign rel_target = id_pc + id_offset;
  assign jalr_sum   = id_data_rs1 + id_offset;
  assign eq         = (id_data_rs1 == id_data_rs2);
  assign lt_s       = ($signed(id_data_rs1) < $signed(id_data_rs2));
  assign lt_u       = (id_data_rs1 < id_data_rs2);

  always_comb begin
    op_defined   = 1'b1;
    is_jump      = 1'b0;
    branch_taken = 1'b0;
    pc_branch    = rel_target;
    case (op_e'(id_operation))
      OP_JAL:  begin branch_taken = 1'b1; is_jump = 1'b1; end
      OP_JALR: begin
        branch_taken = 1'b1;
        is_jump      = 1'b1;
        pc_branch    = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BEQ:  branch_taken = eq;
      OP_BNE:  branch_taken = ~eq;
      OP_BLT:  branch_taken = lt_s;
      OP_BGE:  branch_taken = ~lt_s;
      OP_BLTU: branch_taken = lt_u;
      OP_BGEU: branch_taken = ~lt_u;
      default: begin op_defined = 1'b0; pc_branch = '0; end
    endcase
  end

  assign mispredict  = id_valid && ((branch_taken != id_pred_taken) ||
                                    (branch_taken && (pc_branch != id_pred_target)));
  assign redirect_pc = branch_taken ? pc_branch : (id_pc + XLEN'(4));

  // Table update; a not-taken miss leaves the table alone.
  logic [IDX-1:0]      id_idx;
  logic [TAG_W-1:0]    id_tag;
  logic                id_hit, upd_en;
  logic [CNT_BITS-1:0] cnt_cur, cnt_nxt;

  assign id_idx  = id_pc[IDX+1:2];
  assign id_tag  = id_pc[XLEN-1:IDX+2];
  assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign upd_en  = id_valid && !id_stall && op_defined && (branch_taken || id_hit);
  assign cnt_cur = id_hit ? cnt_q[id_idx] : CNT_WT;

  elbeth_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
    .cnt       (cnt_cur),
    .inc       (id_hit && branch_taken),
    .dec       (id_hit && !branch_taken),
    .force_max (is_jump),
    .nxt       (cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= {BTB_ENTRIES{BTB_VALID_RST}};
      tag_q    <= '0;
      target_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) cnt_q[i] <= CNT_RST;
    end else if (upd_en) begin
      valid_q[id_idx] <= 1'b1;
      cnt_q[id_idx]   <= cnt_nxt;
      if (branch_taken) begin
        tag_q[id_idx]    <= id_tag;
        target_q[id_idx] <= pc_branch;
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

endmodule

// File: tb/tb_elbeth_branch_predictor.sv
// Directed bench for elbeth_branch_predictor: expectations are queued when
// stimulus is driven and popped against the DUT outputs.
module tb_elbeth_branch_predictor;
  import elbeth_branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        id_valid = 1'b0, id_stall = 1'b0;
  logic [31:0] id_pc = '0, id_offset = '0;
  logic [2:0]  id_operation = '0;
  logic [31:0] id_data_rs1 = '0, id_data_rs2 = '0;
  logic        id_pred_taken = 1'b0;
  logic [31:0] id_pred_target = '0;
  logic [31:0] pc_branch, redirect_pc;
  logic        branch_taken, mispredict;

  elbeth_branch_predictor #(.XLEN(32), .BTB_ENTRIES(16), .CNT_BITS(2)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .id_valid(id_valid), .id_stall(id_stall), .id_pc(id_pc),
    .id_offset(id_offset), .id_operation(id_operation),
    .id_data_rs1(id_data_rs1), .id_data_rs2(id_data_rs2),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .pc_branch(pc_branch), .branch_taken(branch_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    exp_q.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t x;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      x = exp_q.pop_front();
      assert (obs === x.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Lookup check against the current table contents.
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic et, input logic [31:0] etgt);
    if_pc = pc;
    push({tag, "_taken"}, {31'd0, et});
    push({tag, "_target"}, etgt);
    #1;
    pop_cmp({31'd0, if_pred_taken});
    pop_cmp(if_pred_target);
  endtask

  // One ID resolution: drive at negedge, check outputs, let the edge update.
  task automatic res(input string tag, input op_e op, input logic [31:0] pc,
                     input logic [31:0] off, input logic [31:0] r1, input logic [31:0] r2,
                     input logic pt, input logic [31:0] ptgt, input logic vld, input logic stl,
                     input logic et, input logic [31:0] epb, input logic emp, input logic [31:0] erd);
    @(negedge clk);
    id_valid = vld; id_stall = stl; id_pc = pc; id_offset = off;
    id_operation = op; id_data_rs1 = r1; id_data_rs2 = r2;
    id_pred_taken = pt; id_pred_target = ptgt;
    push({tag, "_branch_taken"}, {31'd0, et});
    push({tag, "_pc_branch"}, epb);
    push({tag, "_mispredict"}, {31'd0, emp});
    push({tag, "_redirect_pc"}, erd);
    #1;
    pop_cmp({31'd0, branch_taken});
    pop_cmp(pc_branch);
    pop_cmp({31'd0, mispredict});
    pop_cmp(redirect_pc);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    id_stall = 1'b0;
  endtask

  initial begin
    #3;
    look("rst_hold", 32'h100, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    look("rst_after", 32'h100, 1'b0, 32'h0);

    // Allocation on a mispredicted taken BEQ, then strengthen to 3.
    res("beq_alloc", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b1, 32'h120, 1'b1, 32'h120);
    look("beq_alloc_lk", 32'h100, 1'b1, 32'h120);
    res("beq_hit", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120, 1'b1, 1'b0,
        1'b1, 32'h120, 1'b0, 32'h120);

    // Hysteresis: 3 -> 2 -> 1 -> 0
    res("nt1", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd6, 1'b1, 32'h120, 1'b1, 1'b0,
        1'b0, 32'h120, 1'b1, 32'h104);
    look("nt1_lk", 32'h100, 1'b1, 32'h120);
    res("nt2", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd6, 1'b1, 32'h120, 1'b1, 1'b0,
        1'b0, 32'h120, 1'b1, 32'h104);
    look("nt2_lk", 32'h100, 1'b0, 32'h120);
    res("nt3", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd6, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b0, 32'h120, 1'b0, 32'h104);
    res("nt4", OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd6, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b0, 32'h120, 1'b0, 32'h104);
    look("nt4_lk", 32'h100, 1'b0, 32'h120);

    // Aliasing on index 0 and signed/unsigned compares
    look("alias_miss", 32'h140, 1'b0, 32'h0);
    res("bltu_nt", OP_BLTU, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b0, 32'h210, 1'b0, 32'h204);
    look("bltu_nochg", 32'h100, 1'b0, 32'h120);
    res("blt_t", OP_BLT, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b1, 32'h210, 1'b1, 32'h210);
    look("alias_old", 32'h100, 1'b0, 32'h0);
    look("alias_new", 32'h200, 1'b1, 32'h210);

    // JALR target masking and forced-strong counter
    res("jalr", OP_JALR, 32'h300, 32'h4, 32'h1003, 32'h0, 1'b1, 32'h1008, 1'b1, 1'b0,
        1'b1, 32'h1006, 1'b1, 32'h1006);
    look("jalr_lk", 32'h300, 1'b1, 32'h1006);
    res("jalr_nt", OP_BEQ, 32'h300, 32'h4, 32'd1, 32'd2, 1'b1, 32'h1006, 1'b1, 1'b0,
        1'b0, 32'h304, 1'b1, 32'h304);
    look("jalr_cnt3", 32'h300, 1'b1, 32'h1006);

    res("jal_neg", OP_JAL, 32'h400, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b1, 32'h3F8, 1'b1, 32'h3F8);
    look("jal_lk", 32'h400, 1'b1, 32'h3F8);
    res("bge_nt", OP_BGE, 32'h104, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b0, 32'h10C, 1'b0, 32'h108);
    res("bgeu_t", OP_BGEU, 32'h104, 32'h8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0,
        1'b1, 32'h10C, 1'b1, 32'h10C);
    look("bgeu_lk", 32'h104, 1'b1, 32'h10C);
    look("idx0_kept", 32'h400, 1'b1, 32'h3F8);

    // Stall and invalid suppress updates; resolution still computed
    res("stall", OP_BNE, 32'h500, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0, 1'b1, 1'b1,
        1'b1, 32'h540, 1'b1, 32'h540);
    look("stall_miss", 32'h500, 1'b0, 32'h0);
    look("stall_kept", 32'h400, 1'b1, 32'h3F8);
    res("novalid", OP_BNE, 32'h500, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0, 1'b0, 1'b0,
        1'b1, 32'h540, 1'b0, 32'h540);
    look("novalid_miss", 32'h500, 1'b0, 32'h0);

    // Reset pulsed mid-cycle with a valid ID instruction present
    @(negedge clk);
    id_valid = 1'b1; id_pc = 32'h108; id_offset = 32'h10;
    id_operation = OP_BEQ; id_data_rs1 = 32'd7; id_data_rs2 = 32'd7;
    id_pred_taken = 1'b0; id_pred_target = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push("rst_mid_branch_taken", 32'd1);
    push("rst_mid_pc_branch", 32'h118);
    #1;
    pop_cmp({31'd0, branch_taken});
    pop_cmp(pc_branch);
    look("rst_mid_lk", 32'h108, 1'b0, 32'h0);
    @(negedge clk);
    id_valid = 1'b0;
    rst = 1'b0;
    #1;
    look("post_rst_108", 32'h108, 1'b0, 32'h0);
    look("post_rst_400", 32'h400, 1'b0, 32'h0);
    look("post_rst_104", 32'h104, 1'b0, 32'h0);
    look("post_rst_300", 32'h300, 1'b0, 32'h0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
